// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing helpers for the FIFO pointer/flag controller.
// Depth and count width derive from the address width.
package fifo_ctrl_pkg;

  function automatic int depth(input int n);
    return 1 << n;
  endfunction

  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with sync active-low reset,
// sync clear and increment enable.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy, flag and sticky-error controller
// for a single-clock FIFO on a 2**N-entry dual-port RAM.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int N        = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         write,
  input  logic         read,
  input  logic         flush,
  input  logic         clr_err,
  output logic [N-1:0] wr_addr,
  output logic [N-1:0] rd_addr,
  output logic         ram_we,
  output logic         ram_re,
  output logic         rd_valid,
  output logic [N:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);

  localparam int D  = depth(N);
  localparam int CW = cnt_w(N);

  if (AF_LEVEL < 1 || AF_LEVEL > D) begin : g_af_chk
    $error("fifo_ctrl: AF_LEVEL out of range");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > D - 1) begin : g_ae_chk
    $error("fifo_ctrl: AE_LEVEL out of range");
  end

  logic [CW-1:0] wptr, rptr;
  logic [CW-1:0] count_q, count_d;
  logic          rdv_q, rdv_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  assign full         = count_q == CW'(D);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);

  assign ram_we = write & ~full & ~flush;
  assign ram_re = read & ~empty & ~flush;

  fifo_ptr #(.W(CW)) u_wptr (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (flush),
    .inc_i (ram_we),
    .ptr_o (wptr)
  );

  fifo_ptr #(.W(CW)) u_rptr (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (flush),
    .inc_i (ram_re),
    .ptr_o (rptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush)                count_d = '0;
    else if (ram_we && !ram_re) count_d = count_q + 1'b1;
    else if (ram_re && !ram_we) count_d = count_q - 1'b1;
    rdv_d = ram_re;
    // set dominates clear; flush never raises an error
    ovf_d = (ovf_q & ~clr_err) | (write & full & ~flush);
    unf_d = (unf_q & ~clr_err) | (read & empty & ~flush);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      rdv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      rdv_q   <= rdv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign wr_addr   = wptr[N-1:0];
  assign rd_addr   = rptr[N-1:0];
  assign count     = count_q;
  assign rd_valid  = rdv_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  a_count_inv: assert property (
    @(posedge clk) disable iff (!rst) count_q == wptr - rptr);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: reference model per cycle
// plus a queue of expected rd_valid cycles.
module tb_fifo_ctrl;

  localparam int N  = 3;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         write = 1'b0, read = 1'b0;
  logic         flush = 1'b0, clr_err = 1'b0;
  logic [N-1:0] wr_addr, rd_addr;
  logic         ram_we, ram_re, rd_valid;
  logic [N:0]   count;
  logic         full, empty, almost_full, almost_empty;
  logic         overflow, underflow;

  fifo_ctrl #(.N(N), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .read        (read),
    .flush       (flush),
    .clr_err     (clr_err),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .rd_valid    (rd_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdv_q[$];

  int m_cnt, m_wp, m_rp;
  bit m_ovf, m_unf;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit f,
                      input bit c, input bit rs = 1'b1);
    bit ew, er, ev, mfull, mempty;
    @(negedge clk);
    write = w; read = r; flush = f; clr_err = c; rst = rs;
    #1;
    mfull  = (m_cnt == D);
    mempty = (m_cnt == 0);
    ew = w & ~mfull & ~f;
    er = r & ~mempty & ~f;
    ev = (rdv_q.size() > 0) && (rdv_q[0] == cyc);
    if (ev) void'(rdv_q.pop_front());
    check("rd_valid", int'(rd_valid), int'(ev));
    check("count", int'(count), m_cnt);
    check("wr_addr", int'(wr_addr), m_wp % D);
    check("rd_addr", int'(rd_addr), m_rp % D);
    check("full", int'(full), int'(mfull));
    check("empty", int'(empty), int'(mempty));
    check("almost_full", int'(almost_full), int'(m_cnt >= AF));
    check("almost_empty", int'(almost_empty), int'(m_cnt <= AE));
    check("overflow", int'(overflow), int'(m_ovf));
    check("underflow", int'(underflow), int'(m_unf));
    check("inv_cnt", m_cnt, (m_wp - m_rp) & 15);
    if (rs) begin
      check("ram_we", int'(ram_we), int'(ew));
      check("ram_re", int'(ram_re), int'(er));
    end
    @(posedge clk);
    if (!rs) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
      rdv_q.delete();
    end else begin
      m_ovf = (m_ovf & ~c) | (w & mfull & ~f);
      m_unf = (m_unf & ~c) | (r & mempty & ~f);
      if (f) begin
        m_cnt = 0; m_wp = 0; m_rp = 0;
      end else begin
        if (er) rdv_q.push_back(cyc + 1);
        m_wp = (m_wp + int'(ew)) & 15;
        m_rp = (m_rp + int'(er)) & 15;
        m_cnt = m_cnt + int'(ew) - int'(er);
      end
    end
    cyc++;
  endtask

  initial begin
    m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    end
    step(0, 1, 0, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 7) == 0));
    step(0, 0, 0, 0);
    if (rdv_q.size() != 0) check("rdv_queue_drain", rdv_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
